capture_controller: RTL and testbench
=====================================

CAPTURE_CONTROLLER -- requirements
Module: capture_controller

Interface
REQ-001 Parameter SAMPLE_WIDTH, default 8, number of sample channels.
REQ-002 Parameter ADDR_WIDTH, default 10, sample-buffer address width; buffer depth is DEPTH = 2^ADDR_WIDTH.
REQ-003 clk  input  1  single capture clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 start / abort  input  1 each  single-cycle capture start / capture cancel strobes.
REQ-006 sampleValid  input  1  qualifies sample on this cycle.
REQ-007 sample  input  SAMPLE_WIDTH  channel values.
REQ-008 activeChannels, desiredPattern, dontCareChannels  input  SAMPLE_WIDTH each  trigger/channel configuration.
REQ-009 edgeChannel  input  32  edge-trigger channel index; edgeType, edgeTriggerEnabled, patternTriggerEnabled  input  1 each.
REQ-010 preTrigCount / postTrigCount  input  ADDR_WIDTH each  samples kept before / after the trigger sample.
REQ-011 wrEn  output  1; wrAddr  output  ADDR_WIDTH; wrData  output  SAMPLE_WIDTH  sample-buffer write port.
REQ-012 triggerAddr  output  ADDR_WIDTH  buffer address of the trigger sample.
REQ-013 busy / done  output  1 each  capture in progress / capture complete; state  output  3  current FSM encoding.

Function
REQ-014 FSM states: IDLE, FILL, ARMED, POST, DONE.
REQ-015 start in IDLE or DONE latches all configuration inputs, clears wrAddr, sample count and prevValid, and enters FILL, or ARMED if preTrigCount is 0; start is ignored in all other states.
REQ-016 An accepted sample is a cycle with sampleValid high in FILL, ARMED or POST.
REQ-017 Each accepted sample is written one cycle later: wrEn=1, wrData=sample, wrAddr=current write pointer; the pointer then increments modulo DEPTH.
REQ-018 Each accepted sample updates the previous-sample register and sets prevValid; trigger and transition are computed from sample versus the previous-sample register using the latched configuration.
REQ-019 FILL moves to ARMED once preTrigCount samples have been accepted; preTrigCount is saturated to DEPTH-1.
REQ-020 In ARMED, an accepted sample with prevValid=1 and trigger true is written, its address is latched into triggerAddr, and the FSM enters POST; if postTrigCount is 0 it enters DONE instead.
REQ-021 In ARMED, writes wrap freely around the buffer, overwriting the oldest samples.
REQ-022 POST accepts exactly postTrigCount further samples, then enters DONE; postTrigCount is saturated to DEPTH-1-preTrigCount.
REQ-023 busy=1 in FILL, ARMED and POST; done=1 in DONE and holds until the next start; no writes occur in IDLE or DONE.
REQ-024 abort has priority over start and sampleValid in every state: the FSM returns to IDLE next cycle, and any write already pending from the previous cycle completes.

Reset
REQ-025 On rst_n low: state=IDLE, wrEn=0, wrAddr=0, wrData=0, triggerAddr=0, busy=0, done=0, prevValid=0, previous-sample register=0; takes effect without a clock edge.

Configuration
REQ-026 With LA_TRANSITION_ONLY_EN defined, accepted samples in ARMED and POST are written only when transition is true or the sample is the trigger sample, and only written samples count toward postTrigCount.
REQ-027 Without LA_TRANSITION_ONLY_EN, every accepted sample is written.

Structure
REQ-028 The shared package la_pkg holds the FSM state encoding constants and the default SAMPLE_WIDTH and ADDR_WIDTH.
REQ-029 The block instantiates one TriggerTransDetection sub-module for trigger and transition evaluation; all sequencing lives in capture_controller.

Verification
REQ-030 Drive preTrig=4, postTrig=3, positive edge on channel 0, samples 0,0,0,0,0,1,0,0,0 -> 9 writes at addr 0..8, triggerAddr=5, done after the 9th write.
REQ-031 Drive a trigger condition during FILL at sample 2 with preTrig=4 -> no trigger; capture stays in FILL until 4 samples are accepted.
REQ-032 Use ADDR_WIDTH=3, preTrig=2, and a trigger on the 11th sample -> wrAddr wraps 7->0, triggerAddr=2.
REQ-033 Pulse abort in POST with sampleValid high -> IDLE next cycle, at most one pending write, done=0.
REQ-034 Assert rst_n low mid-ARMED between clock edges -> all outputs zero immediately.
REQ-035 With LA_TRANSITION_ONLY_EN, drive a constant sample for 20 cycles in ARMED -> zero writes.

Source files
------------

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture path: FSM encoding and
// default geometry.
package la_pkg;

    localparam int LA_SAMPLE_WIDTH = 8;
    localparam int LA_ADDR_WIDTH   = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } la_state_e;

endpackage

// File: rtl/capture_controller_trigger.sv
// TriggerTransDetection: combinational trigger / transition evaluation of the
// current sample against the previous accepted sample.
module TriggerTransDetection
    import la_pkg::*;
#(
    parameter int SAMPLE_WIDTH = LA_SAMPLE_WIDTH
) (
    input  logic [SAMPLE_WIDTH-1:0] sample_i,
    input  logic [SAMPLE_WIDTH-1:0] prev_sample_i,
    input  logic                    prev_valid_i,
    input  logic [SAMPLE_WIDTH-1:0] active_channels_i,
    input  logic [SAMPLE_WIDTH-1:0] desired_pattern_i,
    input  logic [SAMPLE_WIDTH-1:0] dont_care_channels_i,
    input  logic [31:0]             edge_channel_i,
    input  logic                    edge_type_i,
    input  logic                    edge_trigger_en_i,
    input  logic                    pattern_trigger_en_i,
    output logic                    trigger_o,
    output logic                    transition_o
);

    localparam int IDX_W = (SAMPLE_WIDTH > 1) ? $clog2(SAMPLE_WIDTH) : 1;

    logic [IDX_W-1:0] edge_idx_s;
    logic             edge_hit_s;
    logic             pattern_hit_s;

    assign edge_idx_s = edge_channel_i[IDX_W-1:0];

    // Edge and pattern match; edgeType=1 selects a rising edge, an out-of-range channel never hits.
    always_comb begin
        edge_hit_s    = 1'b0;
        pattern_hit_s = (((sample_i ^ desired_pattern_i) & active_channels_i
                          & ~dont_care_channels_i) == '0);
        if (edge_channel_i < 32'(SAMPLE_WIDTH)) begin
            if (edge_type_i) begin
                edge_hit_s = sample_i[edge_idx_s] & ~prev_sample_i[edge_idx_s];
            end else begin
                edge_hit_s = ~sample_i[edge_idx_s] & prev_sample_i[edge_idx_s];
            end
        end else begin
            edge_hit_s = 1'b0;
        end
    end

    // With both trigger kinds disabled nothing ever fires; enabled kinds must all match.
    assign trigger_o = prev_valid_i
                     & (edge_trigger_en_i | pattern_trigger_en_i)
                     & (~edge_trigger_en_i | edge_hit_s)
                     & (~pattern_trigger_en_i | pattern_hit_s);

    assign transition_o = prev_valid_i
                        & (((sample_i ^ prev_sample_i) & active_channels_i) != '0);

endmodule

// File: rtl/capture_controller.sv
// Capture sequencer: pre-trigger fill, armed ring-buffer writing, post-trigger
// count. Define LA_TRANSITION_ONLY_EN to store only changed samples once armed.
module capture_controller
    import la_pkg::*;
#(
    parameter int SAMPLE_WIDTH = LA_SAMPLE_WIDTH,
    parameter int ADDR_WIDTH   = LA_ADDR_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic                    sampleValid,
    input  logic [SAMPLE_WIDTH-1:0] sample,
    input  logic [SAMPLE_WIDTH-1:0] activeChannels,
    input  logic [SAMPLE_WIDTH-1:0] desiredPattern,
    input  logic [SAMPLE_WIDTH-1:0] dontCareChannels,
    input  logic [31:0]             edgeChannel,
    input  logic                    edgeType,
    input  logic                    edgeTriggerEnabled,
    input  logic                    patternTriggerEnabled,
    input  logic [ADDR_WIDTH-1:0]   preTrigCount,
    input  logic [ADDR_WIDTH-1:0]   postTrigCount,
    output logic                    wrEn,
    output logic [ADDR_WIDTH-1:0]   wrAddr,
    output logic [SAMPLE_WIDTH-1:0] wrData,
    output logic [ADDR_WIDTH-1:0]   triggerAddr,
    output logic                    busy,
    output logic                    done,
    output logic [2:0]              state
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

    la_state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]     ptr_q, ptr_d, cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]     pre_q, pre_d, post_q, post_d;
    logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d, trig_addr_q, trig_addr_d;
    logic [SAMPLE_WIDTH-1:0]   wr_data_q, wr_data_d, prev_sample_q, prev_sample_d;
    logic [SAMPLE_WIDTH-1:0]   act_q, act_d, pat_q, pat_d, dc_q, dc_d;
    logic [31:0]               edge_ch_q, edge_ch_d;
    logic                      edge_type_q, edge_type_d, edge_en_q, edge_en_d;
    logic                      pat_en_q, pat_en_d;
    logic                      wr_en_q, wr_en_d, prev_valid_q, prev_valid_d;
    logic                      trigger_s, transition_s, keep_s, write_s, accept_s;
    logic [ADDR_WIDTH-1:0]     post_room_s, post_sat_s;

    TriggerTransDetection #(.SAMPLE_WIDTH(SAMPLE_WIDTH)) u_trig (
        .sample_i             (sample),
        .prev_sample_i        (prev_sample_q),
        .prev_valid_i         (prev_valid_q),
        .active_channels_i    (act_q),
        .desired_pattern_i    (pat_q),
        .dont_care_channels_i (dc_q),
        .edge_channel_i       (edge_ch_q),
        .edge_type_i          (edge_type_q),
        .edge_trigger_en_i    (edge_en_q),
        .pattern_trigger_en_i (pat_en_q),
        .trigger_o            (trigger_s),
        .transition_o         (transition_s)
    );

`ifdef LA_TRANSITION_ONLY_EN
    assign keep_s = transition_s;
`else
    assign keep_s = 1'b1;
`endif

    // preTrigCount already fits in DEPTH-1; the post window takes what the pre window leaves.
    assign post_room_s = ADDR_MAX - preTrigCount;
    assign post_sat_s  = (postTrigCount > post_room_s) ? post_room_s : postTrigCount;
    assign accept_s    = sampleValid & ((state_q == ST_FILL) | (state_q == ST_ARMED)
                                        | (state_q == ST_POST));

    // Next-state, write-port and configuration-latch logic.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        cnt_d         = cnt_q;
        pre_d         = pre_q;
        post_d        = post_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        trig_addr_d   = trig_addr_q;
        prev_sample_d = prev_sample_q;
        prev_valid_d  = prev_valid_q;
        act_d         = act_q;
        pat_d         = pat_q;
        dc_d          = dc_q;
        edge_ch_d     = edge_ch_q;
        edge_type_d   = edge_type_q;
        edge_en_d     = edge_en_q;
        pat_en_d      = pat_en_q;
        write_s       = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        act_d        = activeChannels;
                        pat_d        = desiredPattern;
                        dc_d         = dontCareChannels;
                        edge_ch_d    = edgeChannel;
                        edge_type_d  = edgeType;
                        edge_en_d    = edgeTriggerEnabled;
                        pat_en_d     = patternTriggerEnabled;
                        pre_d        = preTrigCount;
                        post_d       = post_sat_s;
                        ptr_d        = '0;
                        wr_addr_d    = '0;
                        cnt_d        = '0;
                        prev_valid_d = 1'b0;
                        state_d      = (preTrigCount == '0) ? ST_ARMED : ST_FILL;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_FILL: begin
                    if (sampleValid) begin
                        write_s = 1'b1;
                        cnt_d   = cnt_q + ADDR_ONE;
                        if ((cnt_q + ADDR_ONE) == pre_q) begin
                            cnt_d   = '0;
                            state_d = ST_ARMED;
                        end else begin
                            state_d = ST_FILL;
                        end
                    end else begin
                        state_d = ST_FILL;
                    end
                end
                ST_ARMED: begin
                    if (sampleValid && trigger_s) begin
                        write_s     = 1'b1;
                        trig_addr_d = ptr_q;
                        cnt_d       = '0;
                        state_d     = (post_q == '0) ? ST_DONE : ST_POST;
                    end else if (sampleValid && keep_s) begin
                        write_s = 1'b1;
                    end else begin
                        write_s = 1'b0;
                    end
                end
                ST_POST: begin
                    if (sampleValid && keep_s) begin
                        write_s = 1'b1;
                        cnt_d   = cnt_q + ADDR_ONE;
                        if ((cnt_q + ADDR_ONE) == post_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_POST;
                        end
                    end else begin
                        state_d = ST_POST;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (accept_s) begin
                prev_sample_d = sample;
                prev_valid_d  = 1'b1;
            end else begin
                prev_valid_d = prev_valid_d;
            end
        end

        if (write_s) begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = sample;
            ptr_d     = ptr_q + ADDR_ONE;
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // State, write-port and latched-configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            ptr_q         <= '0;
            cnt_q         <= '0;
            pre_q         <= '0;
            post_q        <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            trig_addr_q   <= '0;
            prev_sample_q <= '0;
            prev_valid_q  <= 1'b0;
            act_q         <= '0;
            pat_q         <= '0;
            dc_q          <= '0;
            edge_ch_q     <= 32'd0;
            edge_type_q   <= 1'b0;
            edge_en_q     <= 1'b0;
            pat_en_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            cnt_q         <= cnt_d;
            pre_q         <= pre_d;
            post_q        <= post_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            trig_addr_q   <= trig_addr_d;
            prev_sample_q <= prev_sample_d;
            prev_valid_q  <= prev_valid_d;
            act_q         <= act_d;
            pat_q         <= pat_d;
            dc_q          <= dc_d;
            edge_ch_q     <= edge_ch_d;
            edge_type_q   <= edge_type_d;
            edge_en_q     <= edge_en_d;
            pat_en_q      <= pat_en_d;
        end
    end

    assign wrEn        = wr_en_q;
    assign wrAddr      = wr_addr_q;
    assign wrData      = wr_data_q;
    assign triggerAddr = trig_addr_q;
    assign busy        = (state_q == ST_FILL) | (state_q == ST_ARMED) | (state_q == ST_POST);
    assign done        = (state_q == ST_DONE);
    assign state       = state_q;

endmodule

// File: tb/tb_capture_controller.sv
// Scoreboard bench for capture_controller: a default-geometry instance and an
// ADDR_WIDTH=3 instance share stimulus; expected writes are queued per instance.
module tb_capture_controller;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n, start_a, start_b, abort, sv;
    logic [7:0]  sample, act, des, dc;
    logic [31:0] ech;
    logic        etype, een, pen;
    logic [9:0]  pre_a, post_a;
    logic [2:0]  pre_b, post_b;

    logic        wr_en_a, busy_a, done_a;
    logic [9:0]  wr_addr_a, trig_a;
    logic [7:0]  wr_data_a;
    logic [2:0]  state_a;
    logic        wr_en_b, busy_b, done_b;
    logic [2:0]  wr_addr_b, trig_b;
    logic [7:0]  wr_data_b;
    logic [2:0]  state_b;

    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    int   s030[9] = '{0, 0, 0, 0, 0, 1, 0, 0, 0};

    always #5 clk = ~clk;

    capture_controller dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .sampleValid(sv),
        .sample(sample), .activeChannels(act), .desiredPattern(des), .dontCareChannels(dc),
        .edgeChannel(ech), .edgeType(etype), .edgeTriggerEnabled(een),
        .patternTriggerEnabled(pen), .preTrigCount(pre_a), .postTrigCount(post_a),
        .wrEn(wr_en_a), .wrAddr(wr_addr_a), .wrData(wr_data_a), .triggerAddr(trig_a),
        .busy(busy_a), .done(done_a), .state(state_a)
    );

    capture_controller #(.SAMPLE_WIDTH(8), .ADDR_WIDTH(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .sampleValid(sv),
        .sample(sample), .activeChannels(act), .desiredPattern(des), .dontCareChannels(dc),
        .edgeChannel(ech), .edgeType(etype), .edgeTriggerEnabled(een),
        .patternTriggerEnabled(pen), .preTrigCount(pre_b), .postTrigCount(post_b),
        .wrEn(wr_en_b), .wrAddr(wr_addr_b), .wrData(wr_data_b), .triggerAddr(trig_b),
        .busy(busy_b), .done(done_b), .state(state_b)
    );

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act_v, exp_v);
        end
    endtask

    // Monitor: pops the expected write whenever an instance presents wrEn.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr_en_a) begin
                checks++;
                if (q_a.size() == 0) begin
                    errors++;
                    $display("FAIL wr_a_unexpected: got addr=%0d data=%0d expected no write",
                             wr_addr_a, wr_data_a);
                end else begin
                    e = q_a.pop_front();
                    if (32'(wr_addr_a) !== e.addr || 32'(wr_data_a) !== e.data) begin
                        errors++;
                        $display("FAIL wr_a: got addr=%0d data=%0d expected addr=%0d data=%0d",
                                 wr_addr_a, wr_data_a, e.addr, e.data);
                    end
                end
            end
            if (wr_en_b) begin
                checks++;
                if (q_b.size() == 0) begin
                    errors++;
                    $display("FAIL wr_b_unexpected: got addr=%0d data=%0d expected no write",
                             wr_addr_b, wr_data_b);
                end else begin
                    e = q_b.pop_front();
                    if (32'(wr_addr_b) !== e.addr || 32'(wr_data_b) !== e.data) begin
                        errors++;
                        $display("FAIL wr_b: got addr=%0d data=%0d expected addr=%0d data=%0d",
                                 wr_addr_b, wr_data_b, e.addr, e.data);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one valid sample; a non-negative address queues the expected write.
    task automatic send(input int s, input int addr_a, input int addr_b);
        sv     = 1'b1;
        sample = s[7:0];
        if (addr_a >= 0) q_a.push_back('{32'(addr_a), 32'(s)});
        if (addr_b >= 0) q_b.push_back('{32'(addr_b), 32'(s)});
        tick();
        sv = 1'b0;
    endtask

    task automatic start_cfg_a(input int pre, input int post);
        pre_a   = pre[9:0];
        post_a  = post[9:0];
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, "_wren"},  32'(wr_en_a),   32'd0);
        chk({tag, "_wraddr"}, 32'(wr_addr_a), 32'd0);
        chk({tag, "_wrdata"}, 32'(wr_data_a), 32'd0);
        chk({tag, "_trig"},  32'(trig_a),    32'd0);
        chk({tag, "_busy"},  32'(busy_a),    32'd0);
        chk({tag, "_done"},  32'(done_a),    32'd0);
        chk({tag, "_state"}, 32'(state_a),   32'd0);
    endtask

    initial begin
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; sv = 1'b0;
        sample = 8'h00; act = 8'hFF; des = 8'h00; dc = 8'h00; ech = 32'd0;
        etype = 1'b1; een = 1'b1; pen = 1'b0;
        pre_a = 10'd0; post_a = 10'd0; pre_b = 3'd0; post_b = 3'd0;
        fork
            monitor();
        join_none
        #3;
        chk_zero_a("reset");
        chk("reset_trig_b", 32'(trig_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic capture: 4 pre, rising edge on ch0 at sample 5, 3 post.
        start_cfg_a(4, 3);
        chk("t030_fill", 32'(state_a), 32'd1);
        chk("t030_busy", 32'(busy_a), 32'd1);
        for (int i = 0; i < 9; i++) begin
            send(s030[i], i, -1);
            if (i == 3) chk("t030_armed", 32'(state_a), 32'd2);
            if (i == 5) chk("t030_post", 32'(state_a), 32'd3);
        end
        chk("t030_done", 32'(done_a), 32'd1);
        chk("t030_busy_lo", 32'(busy_a), 32'd0);
        chk("t030_state", 32'(state_a), 32'd4);
        chk("t030_trig", 32'(trig_a), 32'd5);
        tick();
        chk("t030_wren_idle", 32'(wr_en_a), 32'd0);
        chk("t030_drained", 32'(q_a.size()), 32'd0);

        // Edge during FILL must not trigger; FILL lasts exactly 4 samples.
        start_cfg_a(4, 3);
        chk("t031_done_cleared", 32'(done_a), 32'd0);
        send(0, 0, -1);
        chk("t031_fill1", 32'(state_a), 32'd1);
        send(1, 1, -1);
        chk("t031_fill2", 32'(state_a), 32'd1);
        send(1, 2, -1);
        chk("t031_fill3", 32'(state_a), 32'd1);
        send(1, 3, -1);
        chk("t031_armed", 32'(state_a), 32'd2);
        pulse_abort();
        chk("t031_abort_idle", 32'(state_a), 32'd0);
        chk("t031_drained", 32'(q_a.size()), 32'd0);

        // Small buffer: pointer wraps 7->0, trigger on the 11th sample lands at 2.
        pre_b = 3'd2; post_b = 3'd2; start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int i = 0; i < 13; i++) begin
            send((i == 10) ? 1 : 0, -1, i % 8);
            if (i == 10) chk("t032_post", 32'(state_b), 32'd3);
        end
        chk("t032_trig", 32'(trig_b), 32'd2);
        chk("t032_done", 32'(done_b), 32'd1);
        tick();
        chk("t032_drained", 32'(q_b.size()), 32'd0);

        // Abort in POST with a valid sample: only the already-pending write completes.
        start_cfg_a(1, 3);
        send(0, 0, -1);
        send(1, 1, -1);
        chk("t033_post", 32'(state_a), 32'd3);
        chk("t033_trig", 32'(trig_a), 32'd1);
        sv = 1'b1; sample = 8'h00; abort = 1'b1;
        tick();
        sv = 1'b0; abort = 1'b0;
        chk("t033_idle", 32'(state_a), 32'd0);
        chk("t033_done", 32'(done_a), 32'd0);
        chk("t033_busy", 32'(busy_a), 32'd0);
        chk("t033_no_new_write", 32'(wr_en_a), 32'd0);
        send(1, -1, -1);
        send(0, -1, -1);
        tick();
        chk("t033_drained", 32'(q_a.size()), 32'd0);

        // Asynchronous reset between edges while ARMED with a write pending.
        een = 1'b0;
        start_cfg_a(2, 2);
        send(8'h11, 0, -1);
        send(8'h22, 1, -1);
        chk("t034_armed", 32'(state_a), 32'd2);
        send(8'h33, -1, -1);
        chk("t034_pending", 32'(wr_en_a), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk_zero_a("t034");
        chk("t034_trig_b", 32'(trig_b), 32'd0);
        chk("t034_done_b", 32'(done_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t034_drained", 32'(q_a.size()), 32'd0);

        // Constant sample for 20 cycles while ARMED with no trigger enabled.
        een = 1'b0; pen = 1'b0;
        start_cfg_a(0, 3);
        chk("t035_armed", 32'(state_a), 32'd2);
        for (int i = 0; i < 20; i++) begin
`ifdef LA_TRANSITION_ONLY_EN
            send(8'h5A, -1, -1);
`else
            send(8'h5A, i, -1);
`endif
        end
        tick();
        chk("t035_still_armed", 32'(state_a), 32'd2);
        chk("t035_drained", 32'(q_a.size()), 32'd0);
        pulse_abort();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
